// File: rtl/data_bus_responder.sv
// Memory-backed responder for a req/gnt/rvalid data bus with a word-addressed backing store.
// Grant is combinational; responses return in order RVALID_LATENCY cycles after the grant cycle.
// Grant is withheld by stall_i, until GNT_DELAY wait cycles elapse, or while MAX_OUTSTANDING responses are pending.
module data_bus_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_WORDS       = 256,
  parameter int GNT_DELAY       = 0,
  parameter int RVALID_LATENCY  = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  input  logic                    stall_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int WAIT_W = $clog2(GNT_DELAY + 2);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int LAT    = RVALID_LATENCY;
  localparam logic [IDX_W:0] NUM_WORDS_W = (IDX_W + 1)'(NUM_WORDS);

  // Backing store: deliberately has no reset so contents survive rst_ni.
  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic [LAT-1:0]        rsp_vld_q, rsp_vld_d;
  logic [LAT-1:0]        rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q [LAT];
  logic [DATA_WIDTH-1:0] rsp_rdata_d [LAT];

  logic [IDX_W-1:0]      word_idx;
  logic [MEM_AW-1:0]     mem_addr;
  logic                  in_range;
  logic                  gnt;
  logic                  rsp_retire;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  addr_lsb_unused;

  assign word_idx        = data_addr_i[ADDR_WIDTH-1:2];
  assign mem_addr        = word_idx[MEM_AW-1:0];
  assign in_range        = {1'b0, word_idx} < NUM_WORDS_W;
  assign addr_lsb_unused = ^data_addr_i[1:0];
  assign rsp_retire      = rsp_vld_q[LAT-1];

  // Grant decision uses only registered wait/outstanding state, so a retiring response cannot free a slot this cycle.
  always_comb begin
    gnt = rst_ni & data_req_i & ~stall_i
        & (wait_cnt_q >= WAIT_W'(GNT_DELAY))
        & (outstanding_q < OUT_W'(MAX_OUTSTANDING));
  end

  // Wait counter saturates at GNT_DELAY; a stall keeps it counting, dropping req clears it.
  always_comb begin
    wait_cnt_d = '0;
    if (data_req_i && !gnt) begin
      if (wait_cnt_q >= WAIT_W'(GNT_DELAY)) wait_cnt_d = wait_cnt_q;
      else                                   wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  // Outstanding tracks granted-but-unanswered requests; grant and retire together cancel.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({gnt, rsp_retire})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Access at the grant edge: read the addressed word and merge enabled write bytes over it.
  always_comb begin
    rd_word = in_range ? mem[mem_addr] : '0;
    wr_word = rd_word;
    for (int b = 0; b < BE_W; b++) begin
      if (data_be_i[b]) wr_word[8*b +: 8] = data_wdata_i[8*b +: 8];
    end
    mem_we = gnt & data_we_i & in_range;
  end

  // Response pipeline: stage 0 loads on grant, the last stage drives the outputs.
  always_comb begin
    rsp_vld_d = rsp_vld_q;
    rsp_err_d = rsp_err_q;
    for (int i = 0; i < LAT; i++) rsp_rdata_d[i] = rsp_rdata_q[i];
    for (int i = LAT - 1; i > 0; i--) begin
      rsp_vld_d[i]   = rsp_vld_q[i-1];
      rsp_err_d[i]   = rsp_err_q[i-1];
      rsp_rdata_d[i] = rsp_rdata_q[i-1];
    end
    rsp_vld_d[0]   = gnt;
    rsp_err_d[0]   = gnt & ~in_range;
    rsp_rdata_d[0] = (gnt && !data_we_i && in_range) ? rd_word : '0;
  end

  // Control state and response pipeline; reset flushes in-flight responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q    <= '0;
      outstanding_q <= '0;
      rsp_vld_q     <= '0;
      rsp_err_q     <= '0;
      for (int i = 0; i < LAT; i++) rsp_rdata_q[i] <= '0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      outstanding_q <= outstanding_d;
      rsp_vld_q     <= rsp_vld_d;
      rsp_err_q     <= rsp_err_d;
      for (int i = 0; i < LAT; i++) rsp_rdata_q[i] <= rsp_rdata_d[i];
    end
  end

  // Backing store write port.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_addr] <= wr_word;
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rsp_retire;
  assign data_rdata_o  = rsp_retire ? rsp_rdata_q[LAT-1] : '0;
  assign data_err_o    = rsp_retire & rsp_err_q[LAT-1];

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: four instances share one stimulus stream.
// u_a defaults, u_b GNT_DELAY=3, u_c RVALID_LATENCY=4, u_d RVALID_LATENCY=3.
// Each test looks only at the instance whose parameters it exercises.
module tb_data_bus_responder;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic              stall = 1'b0;
  logic [31:0]       addr = '0;
  logic [31:0]       wdata = '0;
  logic [3:0]        be = '0;
  logic [3:0]        gnt, rvalid, err;
  logic [3:0][31:0]  rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_bus_responder u_a (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata), .stall_i(stall), .data_gnt_o(gnt[0]),
    .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]));

  data_bus_responder #(.GNT_DELAY(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata), .stall_i(stall), .data_gnt_o(gnt[1]),
    .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]));

  data_bus_responder #(.RVALID_LATENCY(4), .MAX_OUTSTANDING(2)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata), .stall_i(stall), .data_gnt_o(gnt[2]),
    .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2]));

  data_bus_responder #(.RVALID_LATENCY(3), .MAX_OUTSTANDING(2)) u_d (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata), .stall_i(stall), .data_gnt_o(gnt[3]),
    .data_rvalid_o(rvalid[3]), .data_rdata_o(rdata[3]), .data_err_o(err[3]));

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    req = r; we = w; addr = a; wdata = d; be = b;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    stall = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 32'h10, 32'h0, 4'hf);
    tick();
    sample();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_checks++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0000", rvalid); end
    n_checks++; if (err !== 4'b0000) begin n_fail++; $display("FAIL reset_err: got %b want 0000", err); end
    n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    rst_n = 1'b1;
    #1;
    // First edge after release can grant; the GNT_DELAY=3 instance must still wait.
    n_checks++; if (gnt !== 4'b1101) begin n_fail++; $display("FAIL first_gnt_after_reset: got %b want 1101", gnt); end
    tick();
    idle(6);
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hf);
    sample();
    n_checks++; if (gnt[0] !== 1'b1) begin n_fail++; $display("FAIL basic_wr_gnt: got %b want 1", gnt[0]); end
    n_checks++; if (rvalid[0] !== 1'b0) begin n_fail++; $display("FAIL basic_wr_no_rvalid: got %b want 0", rvalid[0]); end
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    sample();
    n_checks++; if (gnt[0] !== 1'b1) begin n_fail++; $display("FAIL basic_rd_gnt: got %b want 1", gnt[0]); end
    n_checks++; if ({rvalid[0], err[0], rdata[0]} !== {1'b1, 1'b0, 32'h0})
      begin n_fail++; $display("FAIL basic_wr_rsp: got v=%b e=%b d=%h want v=1 e=0 d=0", rvalid[0], err[0], rdata[0]); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sample();
    n_checks++; if ({rvalid[0], err[0], rdata[0]} !== {1'b1, 1'b0, 32'hDEADBEEF})
      begin n_fail++; $display("FAIL basic_rd_rsp: got v=%b e=%b d=%h want v=1 e=0 d=deadbeef", rvalid[0], err[0], rdata[0]); end
    tick();
    sample();
    n_checks++; if ({rvalid[0], rdata[0]} !== {1'b0, 32'h0})
      begin n_fail++; $display("FAIL basic_rvalid_single: got v=%b d=%h want v=0 d=0", rvalid[0], rdata[0]); end
    tick();
  endtask

  task automatic test_byte_write();
    drive(1'b1, 1'b1, 32'h10, 32'h0000AA00, 4'b0010);
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sample();
    n_checks++; if ({rvalid[0], rdata[0]} !== {1'b1, 32'hDEADAAEF})
      begin n_fail++; $display("FAIL byte_write: got v=%b d=%h want v=1 d=deadaaef", rvalid[0], rdata[0]); end
    tick();
    idle(2);
  endtask

  // Randomised traffic on u_a against a transaction-level model: a word array plus an in-order response queue.
  typedef struct { int due; logic e; logic [31:0] d; } rsp_t;

  task automatic test_random();
    logic [31:0] mem_m [16];
    rsp_t        q[$];
    rsp_t        r;
    logic        hold, exp_g, exp_v, exp_e;
    logic [31:0] exp_d;
    logic [29:0] widx;
    int          oob;
    hold = 1'b0;
    for (int c = 0; c < 420; c++) begin
      if (c < 16) begin
        drive(1'b1, 1'b1, 32'(c * 4), $urandom, 4'hf);
        stall = 1'b0;
      end else if (c >= 416) begin
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        stall = 1'b0;
      end else begin
        if (!hold) begin
          oob = ($urandom_range(0, 7) == 0) ? 1 : 0;
          drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                (oob != 0) ? 32'((256 + $urandom_range(0, 15)) * 4) : 32'($urandom_range(0, 15) * 4),
                $urandom, 4'($urandom));
        end
        stall = ($urandom_range(0, 4) == 0);
      end
      sample();
      // Pending responses are those granted earlier and not yet past their due cycle.
      exp_g = req & ~stall & (q.size() < 2);
      n_checks++; if (gnt[0] !== exp_g) begin n_fail++; $display("FAIL rand_gnt c=%0d: got %b want %b", c, gnt[0], exp_g); end
      exp_v = (q.size() > 0) && (q[0].due == c);
      exp_e = exp_v ? q[0].e : 1'b0;
      exp_d = exp_v ? q[0].d : 32'h0;
      if (exp_v) void'(q.pop_front());
      n_checks++; if ({rvalid[0], err[0], rdata[0]} !== {exp_v, exp_e, exp_d})
        begin n_fail++; $display("FAIL rand_rsp c=%0d: got v=%b e=%b d=%h want v=%b e=%b d=%h", c, rvalid[0], err[0], rdata[0], exp_v, exp_e, exp_d); end
      if (exp_g) begin
        widx = addr[31:2];
        r.due = c + 1;
        if (widx >= 30'd256) begin
          r.e = 1'b1; r.d = 32'h0;
        end else begin
          r.e = 1'b0;
          r.d = we ? 32'h0 : mem_m[widx[3:0]];
          if (we) for (int b = 0; b < 4; b++) if (be[b]) mem_m[widx[3:0]][8*b +: 8] = wdata[8*b +: 8];
        end
        q.push_back(r);
      end
      hold = req & ~exp_g;
      tick();
    end
    idle(6);
  endtask

  task automatic test_gnt_delay();
    idle(3);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      sample();
      n_checks++; if (gnt[1] !== (k == 3)) begin n_fail++; $display("FAIL delay_plain k=%0d: got %b want %b", k, gnt[1], (k == 3)); end
      tick();
    end
    idle(1);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      stall = (k == 3);
      sample();
      n_checks++; if (gnt[1] !== (k == 4)) begin n_fail++; $display("FAIL delay_stall k=%0d: got %b want %b", k, gnt[1], (k == 4)); end
      tick();
    end
    idle(1);
    // Dropping req for a cycle restarts the wait.
    for (int k = 0; k < 7; k++) begin
      drive(k != 2, 1'b0, 32'h0, 32'h0, 4'h0);
      sample();
      n_checks++; if (gnt[1] !== (k == 6)) begin n_fail++; $display("FAIL delay_drop k=%0d: got %b want %b", k, gnt[1], (k == 6)); end
      tick();
    end
    idle(3);
  endtask

  task automatic test_outstanding();
    idle(6);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      sample();
      n_checks++; if (gnt[2] !== (k == 0 || k == 1 || k == 5))
        begin n_fail++; $display("FAIL outst_gnt k=%0d: got %b want %b", k, gnt[2], (k == 0 || k == 1 || k == 5)); end
      n_checks++; if (rvalid[2] !== (k == 4 || k == 5))
        begin n_fail++; $display("FAIL outst_rvalid k=%0d: got %b want %b", k, rvalid[2], (k == 4 || k == 5)); end
      tick();
    end
    idle(6);
  endtask

  task automatic test_oob();
    idle(2);
    drive(1'b1, 1'b1, 32'h0, 32'h12345678, 4'hf);
    sample();
    n_checks++; if (gnt[0] !== 1'b1) begin n_fail++; $display("FAIL oob_w0_gnt: got %b want 1", gnt[0]); end
    tick();
    drive(1'b1, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hf);
    sample();
    n_checks++; if ({rvalid[0], err[0], rdata[0]} !== {1'b1, 1'b0, 32'h0})
      begin n_fail++; $display("FAIL oob_w0_rsp: got v=%b e=%b d=%h want v=1 e=0 d=0", rvalid[0], err[0], rdata[0]); end
    tick();
    drive(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    sample();
    n_checks++; if ({rvalid[0], err[0], rdata[0]} !== {1'b1, 1'b1, 32'h0})
      begin n_fail++; $display("FAIL oob_wr_rsp: got v=%b e=%b d=%h want v=1 e=1 d=0", rvalid[0], err[0], rdata[0]); end
    tick();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    sample();
    n_checks++; if ({rvalid[0], err[0], rdata[0]} !== {1'b1, 1'b1, 32'h0})
      begin n_fail++; $display("FAIL oob_rd_rsp: got v=%b e=%b d=%h want v=1 e=1 d=0", rvalid[0], err[0], rdata[0]); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sample();
    n_checks++; if ({rvalid[0], err[0], rdata[0]} !== {1'b1, 1'b0, 32'h12345678})
      begin n_fail++; $display("FAIL oob_word0_kept: got v=%b e=%b d=%h want v=1 e=0 d=12345678", rvalid[0], err[0], rdata[0]); end
    tick();
    idle(2);
  endtask

  task automatic test_reset_midflight();
    idle(5);
    drive(1'b1, 1'b1, 32'h14, 32'hCAFEF00D, 4'hf);
    sample();
    n_checks++; if (gnt[3] !== 1'b1) begin n_fail++; $display("FAIL mid_wr_gnt: got %b want 1", gnt[3]); end
    tick();
    idle(4);
    drive(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    sample();
    n_checks++; if (gnt[3] !== 1'b1) begin n_fail++; $display("FAIL mid_rd0_gnt: got %b want 1", gnt[3]); end
    tick();
    sample();
    n_checks++; if (gnt[3] !== 1'b1) begin n_fail++; $display("FAIL mid_rd1_gnt: got %b want 1", gnt[3]); end
    tick();
    // Two reads are in flight; pulse reset inside this cycle, no clock edge while low.
    rst_n = 1'b0;
    #1;
    n_checks++; if ({gnt[3], rvalid[3], err[3], rdata[3]} !== {1'b0, 1'b0, 1'b0, 32'h0})
      begin n_fail++; $display("FAIL mid_async_reset: got g=%b v=%b e=%b d=%h want all 0", gnt[3], rvalid[3], err[3], rdata[3]); end
    sample();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 7; k++) begin
      n_checks++; if (gnt[3] !== (k < 2)) begin n_fail++; $display("FAIL mid_post_gnt k=%0d: got %b want %b", k, gnt[3], (k < 2)); end
      n_checks++; if (rvalid[3] !== (k == 3 || k == 4)) begin n_fail++; $display("FAIL mid_post_rvalid k=%0d: got %b want %b", k, rvalid[3], (k == 3 || k == 4)); end
      if (k == 3 || k == 4) begin
        n_checks++; if (rdata[3] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mid_mem_kept k=%0d: got %h want cafef00d", k, rdata[3]); end
      end
      tick();
      if (k == 1) drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      sample();
    end
    tick();
    idle(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_byte_write();
    test_random();
    test_gnt_delay();
    test_outstanding();
    test_oob();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
